// File: rtl/qdec_ctx_arb.sv
// Purpose : three-way arbiter (write-back / read / init) in front of a single-port
//           context-state memory, with read forwarding and starvation override.
// Latency : grant and memory strobes combinational in the request cycle; read
//           response (o_rd_data_vld) one cycle after acceptance.
// Backpressure: o_*_rdy is the combinational grant; losers hold vld/addr/data
//           until granted. Read responses cannot be stalled.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   i_wb_*   / o_wb_rdy            state write-back from the arithmetic decoder
//   i_rd_*   / o_rd_rdy            context read request from the context FSM
//   o_rd_data, o_rd_data_vld       read response
//   i_init_* / o_init_rdy          slice-start context initialisation writes
//   o_ctx_*, i_ctx_rdata           single-port memory (read data one cycle after re)
//   o_busy                         any request valid or read response pending
module qdec_ctx_arb #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 8,
    parameter int STARVE_LIM = 4
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              i_wb_vld,
    input  logic [ADDR_W-1:0] i_wb_addr,
    input  logic [DATA_W-1:0] i_wb_data,
    output logic              o_wb_rdy,

    input  logic              i_rd_vld,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic              o_rd_rdy,

    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_rd_data_vld,

    input  logic              i_init_vld,
    input  logic [ADDR_W-1:0] i_init_addr,
    input  logic [DATA_W-1:0] i_init_data,
    output logic              o_init_rdy,

    output logic [ADDR_W-1:0] o_ctx_addr,
    output logic [DATA_W-1:0] o_ctx_wdata,
    output logic              o_ctx_we,
    output logic              o_ctx_re,
    input  logic [DATA_W-1:0] i_ctx_rdata,

    output logic              o_busy
);

    localparam logic [3:0] LIM     = 4'(STARVE_LIM);
    localparam logic [3:0] CNT_MAX = 4'hF;

    // Denial counters for the two requesters that can lose to write-back.
    logic [3:0]        r_rd_deny;
    logic [3:0]        r_init_deny;

    // Read response pipeline.
    logic              r_rd_pend;
    logic              r_fwd;
    logic [DATA_W-1:0] r_fwd_data;
    logic [DATA_W-1:0] r_rd_hold;

    logic              w_rd_ovr;
    logic              w_init_ovr;
    logic              w_addr_hit;
    logic              w_g_wb;
    logic              w_g_rd;
    logic              w_g_init;
    logic              w_fwd;

    // A requester that has been refused STARVE_LIM times in a row jumps above
    // write-back. A counter only accumulates while vld is held, so a non-zero
    // count always implies the requester is still asking; vld is still ANDed in
    // to keep the override self-evidently safe.
    assign w_rd_ovr   = i_rd_vld   && (r_rd_deny   >= LIM);
    assign w_init_ovr = i_init_vld && (r_init_deny >= LIM) && !w_rd_ovr;

    // Same-address write-back and read can share one memory slot: the write goes
    // to memory and the read is answered from the write data.
    assign w_addr_hit = i_wb_vld && i_rd_vld && (i_wb_addr == i_rd_addr);

    // Grant selection. Gated by rst_n so nothing is granted while in reset,
    // and arbitration is live again as soon as reset is released.
    always_comb begin
        w_g_wb   = 1'b0;
        w_g_rd   = 1'b0;
        w_g_init = 1'b0;
        if (!rst_n) begin
            w_g_wb   = 1'b0;
        end else if (w_rd_ovr) begin
            w_g_rd   = 1'b1;
            w_g_wb   = w_addr_hit;
        end else if (w_init_ovr) begin
            w_g_init = 1'b1;
        end else if (i_wb_vld) begin
            w_g_wb   = 1'b1;
            w_g_rd   = w_addr_hit;
        end else if (i_rd_vld) begin
            w_g_rd   = 1'b1;
        end else if (i_init_vld) begin
            w_g_init = 1'b1;
        end
    end

    assign w_fwd      = w_g_wb && w_g_rd;

    assign o_wb_rdy   = w_g_wb;
    assign o_rd_rdy   = w_g_rd;
    assign o_init_rdy = w_g_init;

    // Memory port mux. A forwarded read issues only the write; the read data
    // comes from the captured write data instead of the memory.
    always_comb begin
        o_ctx_addr  = '0;
        o_ctx_wdata = '0;
        o_ctx_we    = 1'b0;
        o_ctx_re    = 1'b0;
        if (w_g_wb) begin
            o_ctx_addr  = i_wb_addr;
            o_ctx_wdata = i_wb_data;
            o_ctx_we    = 1'b1;
        end else if (w_g_rd) begin
            o_ctx_addr  = i_rd_addr;
            o_ctx_re    = 1'b1;
        end else if (w_g_init) begin
            o_ctx_addr  = i_init_addr;
            o_ctx_wdata = i_init_data;
            o_ctx_we    = 1'b1;
        end
    end

    // Denial counters: clear on grant or when the requester drops vld,
    // otherwise count up and stick at 15.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_deny   <= 4'd0;
            r_init_deny <= 4'd0;
        end else begin
            if (!i_rd_vld || w_g_rd) begin
                r_rd_deny <= 4'd0;
            end else if (r_rd_deny != CNT_MAX) begin
                r_rd_deny <= r_rd_deny + 4'd1;
            end

            if (!i_init_vld || w_g_init) begin
                r_init_deny <= 4'd0;
            end else if (r_init_deny != CNT_MAX) begin
                r_init_deny <= r_init_deny + 4'd1;
            end
        end
    end

    // Response tracking. Reset drops any in-flight read so no stale response
    // appears after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_pend  <= 1'b0;
            r_fwd      <= 1'b0;
            r_fwd_data <= '0;
            r_rd_hold  <= '0;
        end else begin
            r_rd_pend <= w_g_rd;
            r_fwd     <= w_fwd;
            if (w_fwd) begin
                r_fwd_data <= i_wb_data;
            end
            if (r_rd_pend) begin
                r_rd_hold <= o_rd_data;
            end
        end
    end

    // Memory read data is only valid in the cycle after ctx_re, so it is passed
    // straight through in that cycle and the last response is held afterwards.
    assign o_rd_data     = r_rd_pend ? (r_fwd ? r_fwd_data : i_ctx_rdata) : r_rd_hold;
    assign o_rd_data_vld = r_rd_pend;

    assign o_busy = rst_n && (i_wb_vld || i_rd_vld || i_init_vld || r_rd_pend);

endmodule

// File: tb/tb_qdec_ctx_arb.sv
module tb_qdec_ctx_arb;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 8;

    logic              clk;
    logic              rst_n;
    logic              wb_vld;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              wb_rdy;
    logic              rd_vld;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_rdy;
    logic [DATA_W-1:0] rd_data;
    logic              rd_data_vld;
    logic              init_vld;
    logic [ADDR_W-1:0] init_addr;
    logic [DATA_W-1:0] init_data;
    logic              init_rdy;
    logic [ADDR_W-1:0] ctx_addr;
    logic [DATA_W-1:0] ctx_wdata;
    logic              ctx_we;
    logic              ctx_re;
    logic [DATA_W-1:0] ctx_rdata;
    logic              busy;

    int checks = 0;
    int errors = 0;

    qdec_ctx_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIM(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_wb_vld     (wb_vld),
        .i_wb_addr    (wb_addr),
        .i_wb_data    (wb_data),
        .o_wb_rdy     (wb_rdy),
        .i_rd_vld     (rd_vld),
        .i_rd_addr    (rd_addr),
        .o_rd_rdy     (rd_rdy),
        .o_rd_data    (rd_data),
        .o_rd_data_vld(rd_data_vld),
        .i_init_vld   (init_vld),
        .i_init_addr  (init_addr),
        .i_init_data  (init_data),
        .o_init_rdy   (init_rdy),
        .o_ctx_addr   (ctx_addr),
        .o_ctx_wdata  (ctx_wdata),
        .o_ctx_we     (ctx_we),
        .o_ctx_re     (ctx_re),
        .i_ctx_rdata  (ctx_rdata),
        .o_busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port context memory: write-first across cycles, read data one
    // cycle after ctx_re.
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
        ctx_rdata = '0;
    end
    always @(posedge clk) begin
        if (ctx_we) mem[ctx_addr] <= ctx_wdata;
        if (ctx_re) ctx_rdata <= mem[ctx_addr];
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ---------------- reset state, with requests pending ----------------
        rst_n = 1'b0;
        wb_vld = 1'b1;   wb_addr = 10'h001;   wb_data = 8'hAA;
        rd_vld = 1'b1;   rd_addr = 10'h002;
        init_vld = 1'b1; init_addr = 10'h003; init_data = 8'hBB;
        @(negedge clk);
        chk("rst_wb_rdy",   wb_rdy, 0);
        chk("rst_rd_rdy",   rd_rdy, 0);
        chk("rst_init_rdy", init_rdy, 0);
        chk("rst_ctx_we",   ctx_we, 0);
        chk("rst_ctx_re",   ctx_re, 0);
        chk("rst_ctx_addr", ctx_addr, 0);
        chk("rst_ctx_wdat", ctx_wdata, 0);
        chk("rst_busy",     busy, 0);
        chk("rst_rdv",      rd_data_vld, 0);
        chk("rst_rdata",    rd_data, 0);
        tick();
        tick();
        rst_n = 1'b1;
        wb_vld = 1'b0; rd_vld = 1'b0; init_vld = 1'b0;
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_we",   ctx_we, 0);

        // ---------------- init write 0x3F @5, then read @5 ----------------
        tick();
        init_vld = 1'b1; init_addr = 10'd5; init_data = 8'h3F;
        @(negedge clk);
        chk("init_rdy",   init_rdy, 1);
        chk("init_we",    ctx_we, 1);
        chk("init_addr",  ctx_addr, 5);
        chk("init_wdata", ctx_wdata, 8'h3F);
        tick();
        init_vld = 1'b0;
        rd_vld = 1'b1; rd_addr = 10'd5;
        @(negedge clk);
        chk("rd5_rdy", rd_rdy, 1);
        chk("rd5_re",  ctx_re, 1);
        chk("rd5_we",  ctx_we, 0);
        tick();
        rd_vld = 1'b0;
        chk("rd5_vld",  rd_data_vld, 1);
        chk("rd5_data", rd_data, 8'h3F);
        chk("rd5_busy", busy, 1);
        tick();
        chk("rd5_vld_drop", rd_data_vld, 0);
        chk("rd5_hold",     rd_data, 8'h3F);

        // ---------------- forwarding: wb and rd same address ----------------
        wb_vld = 1'b1; wb_addr = 10'h012; wb_data = 8'h41;
        rd_vld = 1'b1; rd_addr = 10'h012;
        @(negedge clk);
        chk("fwd_wb_rdy", wb_rdy, 1);
        chk("fwd_rd_rdy", rd_rdy, 1);
        chk("fwd_we",     ctx_we, 1);
        chk("fwd_re",     ctx_re, 0);
        tick();
        wb_vld = 1'b0; rd_vld = 1'b0;
        chk("fwd_vld",  rd_data_vld, 1);
        chk("fwd_data", rd_data, 8'h41);

        // ---------------- rd starvation under continuous wb ----------------
        tick();
        wb_vld = 1'b1; wb_addr = 10'h020; wb_data = 8'h55;
        rd_vld = 1'b1; rd_addr = 10'h012;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            chk($sformatf("starve_rd_rdy_c%0d", i), rd_rdy, (i == 5) ? 1 : 0);
            chk($sformatf("starve_wb_rdy_c%0d", i), wb_rdy, (i == 5) ? 0 : 1);
            tick();
        end
        rd_vld = 1'b0;
        chk("starve_rd_vld",  rd_data_vld, 1);
        chk("starve_rd_data", rd_data, 8'h41);
        @(negedge clk);
        chk("starve_wb_resume", wb_rdy, 1);
        chk("starve_rd_off",    rd_rdy, 0);
        tick();
        wb_vld = 1'b0;
        tick();

        // ---------------- init starvation behind continuous rd ----------------
        rd_vld = 1'b1; rd_addr = 10'h012;
        init_vld = 1'b1; init_addr = 10'h030; init_data = 8'h77;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk($sformatf("rdinit_init_c%0d", i), init_rdy, (i % 5 == 4) ? 1 : 0);
            chk($sformatf("rdinit_rd_c%0d", i),   rd_rdy,   (i % 5 == 4) ? 0 : 1);
            tick();
        end
        rd_vld = 1'b0; init_vld = 1'b0;
        tick();
        chk("mem_init30", mem[10'h030], 8'h77);

        // ---------------- 8 back-to-back reads ----------------
        for (int i = 0; i < 8; i++) begin
            wb_vld = 1'b1; wb_addr = 10'(i); wb_data = 8'(8'h10 + i);
            @(negedge clk);
            chk($sformatf("fill_wb_rdy_%0d", i), wb_rdy, 1);
            tick();
        end
        wb_vld = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rd_vld = 1'b1; rd_addr = 10'(i);
            @(negedge clk);
            chk($sformatf("b2b_rdy_%0d", i), rd_rdy, 1);
            tick();
            chk($sformatf("b2b_vld_%0d", i),  rd_data_vld, 1);
            chk($sformatf("b2b_data_%0d", i), rd_data, 8'h10 + i);
        end
        rd_vld = 1'b0;
        tick();
        chk("b2b_vld_end",  rd_data_vld, 0);
        chk("b2b_data_end", rd_data, 8'h17);

        // ---------------- reset right after a read acceptance ----------------
        rd_vld = 1'b1; rd_addr = 10'd3;
        @(negedge clk);
        chk("rstrd_rdy", rd_rdy, 1);
        tick();
        rst_n = 1'b0;
        #1;
        chk("rstrd_vld",    rd_data_vld, 0);
        chk("rstrd_data",   rd_data, 0);
        chk("rstrd_busy",   busy, 0);
        chk("rstrd_rd_rdy", rd_rdy, 0);
        chk("rstrd_re",     ctx_re, 0);
        tick();
        chk("rstrd_vld2", rd_data_vld, 0);
        rst_n = 1'b1;
        rd_addr = 10'd5;
        @(negedge clk);
        chk("post_rst_rdy",  rd_rdy, 1);
        chk("post_rst_re",   ctx_re, 1);
        chk("post_rst_addr", ctx_addr, 5);
        tick();
        rd_vld = 1'b0;
        chk("post_rst_vld",  rd_data_vld, 1);
        chk("post_rst_data", rd_data, 8'h15);
        tick();
        chk("post_rst_vld_drop", rd_data_vld, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
